// File: rtl/instr_fetch.sv
// Instruction fetch front end: requests a 16-bit word from instruction memory,
// latches it into the instruction register, decodes the field outputs for the
// datapath, and pulses the start strobe of the execution controller.
// Optional feature macro: FETCH_TIMEOUT_EN adds a 16-cycle memory wait
// watchdog that halts the fetch unit with err set.
module instr_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        s_out,
    input  logic        ctrl_w,
    input  logic [1:0]  nsel,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  reg_num,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [7:0]  pc,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        F_IDLE  = 3'd0,
        F_REQ   = 3'd1,
        F_ISSUE = 3'd2,
        F_EXEC  = 3'd3,
        F_HALT  = 3'd4
    } fstate_t;

    fstate_t     state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        err_q, err_d;
    logic        exec_first_q, exec_first_d;
`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  tmo_q, tmo_d;
`endif

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic is_start_op(input logic [2:0] opc);
        return (opc == 3'b110) || (opc == 3'b101);
    endfunction

    // Next-state, program counter, instruction register and error flag logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        err_d        = err_q;
        exec_first_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tmo_d        = 4'd0;
`endif
        case (state_q)
            F_IDLE: begin
                if (run && ctrl_w) begin
                    state_d = F_REQ;
                end else begin
                    state_d = F_IDLE;
                end
            end
            F_REQ: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 8'd1;
                    state_d = F_ISSUE;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    // Sixteenth consecutive wait cycle gives up on memory.
                    if (tmo_q == 4'hF) begin
                        err_d   = 1'b1;
                        state_d = F_HALT;
                    end else begin
                        tmo_d   = tmo_q + 4'd1;
                        state_d = F_REQ;
                    end
`else
                    state_d = F_REQ;
`endif
                end
            end
            F_ISSUE: begin
                case (ir_q[15:13])
                    3'b110, 3'b101: begin
                        state_d      = F_EXEC;
                        exec_first_d = 1'b1;
                    end
                    3'b111: begin
                        state_d = F_HALT;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = F_HALT;
                    end
                endcase
            end
            F_EXEC: begin
                // Controller still reports wait in the cycle after the start pulse.
                if (!exec_first_q && ctrl_w) begin
                    state_d = F_IDLE;
                end else begin
                    state_d = F_EXEC;
                end
            end
            F_HALT: begin
                state_d = F_HALT;
            end
            default: begin
                state_d = F_IDLE;
            end
        endcase
    end

    // Architectural state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= F_IDLE;
            pc_q         <= 8'h00;
            ir_q         <= 16'h0000;
            err_q        <= 1'b0;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            err_q        <= err_d;
            exec_first_q <= exec_first_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Memory wait watchdog counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= 4'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Register-number select driven by the controller's nsel.
    always_comb begin
        reg_num = 3'b000;
        case (nsel)
            2'b00:   reg_num = ir_q[10:8];
            2'b01:   reg_num = ir_q[7:5];
            2'b10:   reg_num = ir_q[2:0];
            default: reg_num = 3'b000;
        endcase
    end

    assign mem_req  = (state_q == F_REQ);
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign s_out    = (state_q == F_ISSUE) && is_start_op(ir_q[15:13]);
    assign halted   = (state_q == F_HALT);
    assign err      = err_q;
    assign opcode   = ir_q[15:13];
    assign op       = ir_q[12:11];
    assign shift    = ir_q[4:3];
    assign sximm8   = sext8(ir_q[7:0]);
    assign sximm5   = sext5(ir_q[4:0]);

endmodule
